// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that turns a byte stream into little-endian
// 32-bit words and drives the instruction memory load port. The core is held
// off (cpu_hold) while a program is being written.
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] load_addr,
    output logic [31:0]       load_data,
    output logic              load_we,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HDR   = 3'd1;
    localparam logic [2:0] ST_RECV  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd5;

    logic [2:0]        state_q,     state_d;
    logic [1:0]        byte_q,      byte_d;
    logic [7:0]        word_q,      word_d;
    logic [7:0]        count_q,     count_d;
    logic [ADDR_W-1:0] load_addr_q, load_addr_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              done_q,      done_d;

    // Header byte widened so it can be range-checked against DEPTH.
    logic [31:0] hdr_n;
    logic        hdr_ok;
    logic        accept;

    assign hdr_n  = {24'd0, in_data};
    assign hdr_ok = (hdr_n != 32'd0) && (hdr_n <= DEPTH);
    assign accept = in_valid && in_ready;

    // Handshake and status outputs decode straight from the state register so
    // that an asynchronous reset clears them without waiting for an edge.
    always_comb begin
        in_ready  = (state_q == ST_HDR) || (state_q == ST_RECV);
        load_we   = (state_q == ST_WRITE);
        cpu_hold  = (state_q == ST_HDR) || (state_q == ST_RECV) ||
                    (state_q == ST_WRITE) || (state_q == ST_ERR);
        err       = (state_q == ST_ERR);
        done      = done_q;
        load_addr = load_addr_q;
        load_data = load_data_q;
    end

    // Next-state logic: header check, byte assembly, word sequencing.
    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        word_d      = word_q;
        count_d     = count_q;
        load_addr_d = load_addr_q;
        load_data_d = load_data_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (accept) begin
                    if (hdr_ok) begin
                        count_d     = in_data;
                        word_d      = 8'd0;
                        byte_d      = 2'd0;
                        load_addr_d = '0;
                        state_d     = ST_RECV;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_RECV: begin
                if (accept) begin
                    // First byte of a word lands in the least significant lane.
                    case (byte_q)
                        2'd0:    load_data_d[7:0]   = in_data;
                        2'd1:    load_data_d[15:8]  = in_data;
                        2'd2:    load_data_d[23:16] = in_data;
                        default: load_data_d[31:24] = in_data;
                    endcase
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                word_d = word_q + 8'd1;
                byte_d = 2'd0;
                if (word_q == count_q - 8'd1) begin
                    // Address is left on the last word so it never passes the top.
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    load_addr_d = load_addr_q + ADDR_W'(4);
                    state_d     = ST_RECV;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            byte_q      <= 2'd0;
            word_q      <= 8'd0;
            count_q     <= 8'd0;
            load_addr_q <= '0;
            load_data_q <= 32'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            word_q      <= word_d;
            count_q     <= count_d;
            load_addr_q <= load_addr_d;
            load_data_q <= load_data_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven, hand-written and randomized load sessions.
// Expected memory image is the header's word list itself: word i must be
// written at byte address 4*i, nothing else may be written.
module tb_imem_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
    logic              load_we;
    logic              cpu_hold;
    logic              done;
    logic              err;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .load_addr(load_addr), .load_data(load_data), .load_we(load_we),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t cap[$];
    int  done_cnt = 0;

    typedef struct {
        logic [7:0] hdr;
        bit         exp_err;
        bit         incr;
        bit         gaps;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Write/done monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (load_we) begin
                cap.push_back('{addr: load_addr, data: load_data});
                check("we_hold", 64'(cpu_hold), 64'd1);
                check("we_ready", 64'(in_ready), 64'd0);
                check("we_addr_max", 64'(load_addr <= ADDR_W'((DEPTH - 1) * 4)), 64'd1);
            end
            if (done) begin
                done_cnt++;
                check("done_hold", 64'(cpu_hold), 64'd0);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_addr"}, 64'(load_addr), 64'd0);
        check({tag, "_data"}, 64'(load_data), 64'd0);
        check({tag, "_we"}, 64'(load_we), 64'd0);
        check({tag, "_hold"}, 64'(cpu_hold), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte and hold it until the handshake completes.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            n = int'($urandom_range(0, 2));
            repeat (n) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        for (n = 0; n < 50; n++) begin
            bit rdy;
            rdy = in_ready;
            @(negedge clk);
            if (rdy) break;
        end
        if (n == 50) check("byte_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done();
        for (int t = 0; t < 20 && done_cnt == 0; t++) @(negedge clk);
        @(negedge clk);
        check("done_once", 64'(done_cnt), 64'd1);
        check("done_pulse_end", 64'(done), 64'd0);
        check("done_hold_low", 64'(cpu_hold), 64'd0);
    endtask

    task automatic check_image(input logic [31:0] words[$]);
        check("write_count", 64'(cap.size()), 64'(words.size()));
        for (int i = 0; i < words.size() && i < cap.size(); i++) begin
            check("write_addr", 64'(cap[i].addr), 64'(i * 4));
            check("write_data", 64'(cap[i].data), 64'(words[i]));
        end
    endtask

    task automatic run_session(input logic [7:0] hdr, input logic [31:0] words[$],
                               input bit gaps, input bit exp_err);
        cap.delete();
        done_cnt = 0;
        pulse_start();
        check("hdr_ready", 64'(in_ready), 64'd1);
        check("hdr_hold", 64'(cpu_hold), 64'd1);
        check("hdr_err", 64'(err), 64'd0);
        send_byte(hdr, gaps);
        if (exp_err) begin
            in_valid = 1'b0;
            check("err_flag", 64'(err), 64'd1);
            check("err_hold", 64'(cpu_hold), 64'd1);
            check("err_ready", 64'(in_ready), 64'd0);
            repeat (4) @(negedge clk);
            check("err_sticky", 64'(err), 64'd1);
            check("err_nowrite", 64'(cap.size()), 64'd0);
        end else begin
            foreach (words[i]) begin
                for (int k = 0; k < 4; k++) send_byte(words[i][8*k +: 8], gaps);
            end
            in_valid = 1'b0;
            wait_done();
            check_image(words);
        end
        $display("session hdr=%0d err=%0d writes=%0d", hdr, err, cap.size());
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] words[$];
        logic [31:0] w;
        logic [7:0]  h;

        tbl[0] = '{hdr: 8'd0,   exp_err: 1'b1, incr: 1'b0, gaps: 1'b0};
        tbl[1] = '{hdr: 8'd1,   exp_err: 1'b0, incr: 1'b0, gaps: 1'b0};
        tbl[2] = '{hdr: 8'd65,  exp_err: 1'b1, incr: 1'b0, gaps: 1'b1};
        tbl[3] = '{hdr: 8'd1,   exp_err: 1'b0, incr: 1'b0, gaps: 1'b1};
        tbl[4] = '{hdr: 8'd64,  exp_err: 1'b0, incr: 1'b1, gaps: 1'b0};
        tbl[5] = '{hdr: 8'd255, exp_err: 1'b1, incr: 1'b0, gaps: 1'b0};
        tbl[6] = '{hdr: 8'd5,   exp_err: 1'b0, incr: 1'b0, gaps: 1'b1};

        // Reset state.
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal two-word program: 13 00 00 00 93 00 10 00.
        words = '{32'h0000_0013, 32'h0010_0093};
        run_session(8'd2, words, 1'b0, 1'b0);

        // Table of header cases, each a full session.
        for (int v = 0; v < 7; v++) begin
            words.delete();
            if (!tbl[v].exp_err) begin
                for (int i = 0; i < int'(tbl[v].hdr); i++) begin
                    if (tbl[v].incr)
                        words.push_back({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
                    else
                        words.push_back($urandom);
                end
            end
            run_session(tbl[v].hdr, words, tbl[v].gaps, tbl[v].exp_err);
        end

        // Start pulse in the middle of a word must be ignored.
        cap.delete();
        done_cnt = 0;
        w = 32'hCAFE_F00D;
        pulse_start();
        send_byte(8'd1, 1'b0);
        send_byte(w[7:0], 1'b0);
        send_byte(w[15:8], 1'b0);
        in_valid = 1'b0;
        pulse_start();
        check("rs_ready", 64'(in_ready), 64'd1);
        check("rs_err", 64'(err), 64'd0);
        send_byte(w[23:16], 1'b0);
        send_byte(w[31:24], 1'b0);
        in_valid = 1'b0;
        wait_done();
        words = '{w};
        check_image(words);
        $display("session start-in-recv writes=%0d", cap.size());

        // Asynchronous reset during the 3rd byte of word 5.
        cap.delete();
        done_cnt = 0;
        pulse_start();
        send_byte(8'd8, 1'b0);
        for (int i = 0; i < 4; i++) begin
            w = $urandom;
            for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b0);
        end
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h33;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("arst");
        check("arst_writes", 64'(cap.size()), 64'd4);
        @(negedge clk);
        in_valid = 1'b0;
        check("arst_we_low", 64'(load_we), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_after_writes", 64'(cap.size()), 64'd4);
        $display("session reset-mid-word writes=%0d", cap.size());
        words.delete();
        for (int i = 0; i < 3; i++) words.push_back($urandom);
        run_session(8'd3, words, 1'b1, 1'b0);

        // Randomized headers and payloads.
        for (int r = 0; r < 6; r++) begin
            h = 8'($urandom_range(0, 70));
            words.delete();
            if (h != 8'd0 && int'(h) <= DEPTH) begin
                for (int i = 0; i < int'(h); i++) words.push_back($urandom);
            end
            run_session(h, words, 1'b1, (h == 8'd0) || (int'(h) > DEPTH));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
